uart_cmd_framer: RTL
====================

Name: uart_cmd_framer

Overview:
Controller that drains the UART RX FIFO (uart_rx_fifo: empty, pop_data) and sequences the received bytes into fixed-format plotter command frames.
- Hunts for header 0xAA, collects opcode plus X/Y coordinates, and checks an XOR checksum.
- Presents each validated command to the motion/pen controller with a valid/ready handshake.
- Sits between the serial receive path and the plotter command queue; it is the only consumer of the RX FIFO.

Parameters:
- HDR_BYTE, 8'hAA, frame header value.
- TIMEOUT_CYC, 312_500, max clk cycles between bytes inside a frame (about 3 byte times at 9600 bps, 100 MHz).
- TO_W, 19, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- fifo_empty  in  1  RX FIFO empty flag.
- fifo_data  in  8  RX FIFO head byte; first-word-fall-through, valid whenever fifo_empty=0.
- fifo_pop  out  1  consume head byte this cycle; asserted only when fifo_empty=0.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  downstream accepts; transfer occurs when cmd_valid && cmd_ready.
- cmd_op  out  8  opcode.
- cmd_x  out  16  X coordinate, unsigned.
- cmd_y  out  16  Y coordinate, unsigned.
- frame_err  out  1  one-cycle pulse on a checksum, opcode or timeout error.
- ok_cnt  out  16  frames accepted; wraps.
- err_cnt  out  8  frames rejected; saturates at 255.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset state:
  - state=HUNT; fifo_pop=0, cmd_valid=0, frame_err=0.
  - cmd_op/cmd_x/cmd_y=0; ok_cnt=0, err_cnt=0; timeout counter=0.
- Frame format, 7 bytes in order: HDR, OP, XH, XL, YH, YL, CS, where CS = OP^XH^XL^YH^YL.
- fifo_pop is combinational: (state is a byte-consuming state) && !fifo_empty. One byte is consumed per cycle at most.
- State machine (byte-consuming states advance only on cycles where fifo_pop=1):
  - HUNT: pop every byte. If byte==HDR_BYTE -> OP, else stay in HUNT. Non-header bytes are discarded silently; no error, no count.
  - OP: latch the opcode and init the running XOR -> XH.
  - XH, XL, YH, YL: latch into the shadow registers and update the XOR -> next state.
  - CS: if byte==XOR and opcode is in {01 MOVE, 02 DRAW, 03 PEN_UP, 04 PEN_DOWN, 05 HOME} -> OUT. Otherwise pulse frame_err, increment err_cnt, go to HUNT.
  - OUT: cmd_valid=1; cmd_* driven from registers and held stable; no popping, so the FIFO absorbs backpressure. On the handshake: increment ok_cnt -> HUNT. cmd_valid deasserts the cycle after the handshake.
- Header resync: a 0xAA received in OP..CS is treated as data, with no mid-frame resync. An error returns to HUNT.
- Timeout:
  - The counter clears on every pop and in HUNT/OUT.
  - It increments each cycle in OP..CS while fifo_empty=1.
  - At count==TIMEOUT_CYC-1: pulse frame_err, increment err_cnt, go to HUNT. Partial frame data is discarded.
  - If a pop and the timeout expiry fall on the same cycle, the pop wins.
- Back-to-back frames: minimum gap between cmd_valid assertions is 8 cycles (1 OUT handshake plus 7 pops). The first HUNT pop may occur the cycle after the handshake.
- Reset mid-frame or mid-OUT: abandon immediately; the next cycle is the reset state. The FIFO contents are not flushed by this block.
- cmd_* outputs update only on entry to OUT; their values outside OUT are don't-care but must be stable.

Decomposition:
- Shared package plot_cmd_pkg holds:
  - state enum (HUNT, OP, XH, XL, YH, YL, CS, OUT);
  - opcode constants OP_MOVE..OP_HOME;
  - FRAME_LEN=7;
  - struct plot_cmd_t {op, x, y}.
- No sub-module is needed. An optional sat_counter is reusable for err_cnt, but inline logic is acceptable.

Test Plan:
- Valid frame: push AA 01 12 34 56 78, CS=01^12^34^56^78=0x09, with cmd_ready=1 -> one cmd_valid with op=01, x=0x1234, y=0x5678; ok_cnt=1; frame_err never pulses.
- Garbage then frame: push 00 FF 55 followed by a valid frame AA 05 00 00 00 00 05 -> the garbage bytes are popped silently; op=05, x=0, y=0; err_cnt=0.
- Bad checksum: AA 02 00 10 00 20 00 -> frame_err pulses once; err_cnt=1; no cmd_valid. A following valid frame is accepted normally.
- Bad opcode: AA 00 00 00 00 00 00 -> rejected with err_cnt+1.
- Backpressure: hold cmd_ready=0 for 50 cycles with two frames queued -> cmd_* stable, fifo_pop=0 during OUT. After release, two handshakes in order; ok_cnt=2.
- Timeout and reset: send AA 01 then stall for TIMEOUT_CYC cycles -> frame_err pulse, state HUNT. Separately, assert reset after XL -> all outputs go to reset values; the next full frame is accepted.
- Serial end-to-end: drive uart_rx_fifo at 9600 bps with AA 03 00 64 00 C8 AF -> op=03, x=100, y=200.

Source files
------------

// File: rtl/plot_cmd_pkg.sv
// Shared types and constants for the plotter command framer: FSM states,
// opcode set, frame length and the decoded command record.
package plot_cmd_pkg;

    typedef enum logic [2:0] {
        HUNT,
        OP,
        XH,
        XL,
        YH,
        YL,
        CS,
        OUT
    } state_t;

    localparam logic [7:0] OP_MOVE     = 8'h01;
    localparam logic [7:0] OP_DRAW     = 8'h02;
    localparam logic [7:0] OP_PEN_UP   = 8'h03;
    localparam logic [7:0] OP_PEN_DOWN = 8'h04;
    localparam logic [7:0] OP_HOME     = 8'h05;

    localparam int FRAME_LEN = 7;
    localparam int NUM_OPS   = 5;

    localparam logic [7:0] VALID_OPS [NUM_OPS] = '{
        OP_MOVE, OP_DRAW, OP_PEN_UP, OP_PEN_DOWN, OP_HOME
    };

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] x;
        logic [15:0] y;
    } plot_cmd_t;

endpackage

// File: rtl/uart_cmd_framer.sv
// Drains the RX FIFO, hunts for a header byte and assembles checksummed
// plotter command frames, then hands each good command downstream.
module uart_cmd_framer
    import plot_cmd_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE    = 8'hAA,
    parameter int         TIMEOUT_CYC = 312_500,
    parameter int         TO_W        = 19
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_pop,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_x,
    output logic [15:0] cmd_y,
    output logic        frame_err,
    output logic [15:0] ok_cnt,
    output logic [7:0]  err_cnt
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

    state_t          state_reg, state_next;
    plot_cmd_t       shadow_reg, shadow_next;
    plot_cmd_t       cmd_reg, cmd_next;
    logic [7:0]      xor_reg, xor_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic [15:0]     ok_cnt_reg, ok_cnt_next;
    logic [7:0]      err_cnt_reg, err_cnt_next;
    logic            frame_err_reg, frame_err_next;
    logic [NUM_OPS-1:0] op_hit;
    logic            op_ok;
    logic            fail;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_op_match
            assign op_hit[gi] = (shadow_reg.op == VALID_OPS[gi]);
        end
    endgenerate
    assign op_ok = |op_hit;

    // Popping is held off during reset so no FIFO byte is lost while the FSM is frozen.
    assign fifo_pop = (state_reg != OUT) && !fifo_empty && !reset;

    always_comb begin
        state_next     = state_reg;
        shadow_next    = shadow_reg;
        cmd_next       = cmd_reg;
        xor_next       = xor_reg;
        to_cnt_next    = to_cnt_reg;
        ok_cnt_next    = ok_cnt_reg;
        err_cnt_next   = err_cnt_reg;
        frame_err_next = 1'b0;
        fail           = 1'b0;

        // Inter-byte timer only runs while stalled inside a frame; a pop always wins.
        if (state_reg == HUNT || state_reg == OUT || fifo_pop) begin
            to_cnt_next = '0;
        end else if (fifo_empty) begin
            if (to_cnt_reg == TO_MAX) begin
                fail = 1'b1;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end

        case (state_reg)
            HUNT: begin
                if (fifo_pop && fifo_data == HDR_BYTE) begin
                    state_next = OP;
                end
            end
            OP: begin
                if (fifo_pop) begin
                    shadow_next.op = fifo_data;
                    xor_next       = fifo_data;
                    state_next     = XH;
                end
            end
            XH: begin
                if (fifo_pop) begin
                    shadow_next.x[15:8] = fifo_data;
                    xor_next            = xor_reg ^ fifo_data;
                    state_next          = XL;
                end
            end
            XL: begin
                if (fifo_pop) begin
                    shadow_next.x[7:0] = fifo_data;
                    xor_next           = xor_reg ^ fifo_data;
                    state_next         = YH;
                end
            end
            YH: begin
                if (fifo_pop) begin
                    shadow_next.y[15:8] = fifo_data;
                    xor_next            = xor_reg ^ fifo_data;
                    state_next          = YL;
                end
            end
            YL: begin
                if (fifo_pop) begin
                    shadow_next.y[7:0] = fifo_data;
                    xor_next           = xor_reg ^ fifo_data;
                    state_next         = CS;
                end
            end
            CS: begin
                if (fifo_pop) begin
                    if (fifo_data == xor_reg && op_ok) begin
                        cmd_next   = shadow_reg;
                        state_next = OUT;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            OUT: begin
                if (cmd_ready) begin
                    ok_cnt_next = ok_cnt_reg + 16'd1;
                    state_next  = HUNT;
                end
            end
            default: state_next = HUNT;
        endcase

        if (fail) begin
            frame_err_next = 1'b1;
            state_next     = HUNT;
            to_cnt_next    = '0;
            if (err_cnt_reg != 8'hFF) begin
                err_cnt_next = err_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= HUNT;
            shadow_reg    <= '0;
            cmd_reg       <= '0;
            xor_reg       <= '0;
            to_cnt_reg    <= '0;
            ok_cnt_reg    <= '0;
            err_cnt_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shadow_reg    <= shadow_next;
            cmd_reg       <= cmd_next;
            xor_reg       <= xor_next;
            to_cnt_reg    <= to_cnt_next;
            ok_cnt_reg    <= ok_cnt_next;
            err_cnt_reg   <= err_cnt_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign cmd_valid = (state_reg == OUT);
    assign cmd_op    = cmd_reg.op;
    assign cmd_x     = cmd_reg.x;
    assign cmd_y     = cmd_reg.y;
    assign frame_err = frame_err_reg;
    assign ok_cnt    = ok_cnt_reg;
    assign err_cnt   = err_cnt_reg;

endmodule
